gf24mul_dom_pipe: RTL and testbench

//  d-share masked GF(2^4) multiplier for the TI/DOM AES S-box datapath.

---
 rtl/gf24mul_dom_pipe.sv | 81 ++++++++
 tb/tb_gf24mul_dom_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf24mul_dom_pipe.sv
// gf24mul_dom_pipe: d-share DOM masked GF((2^2)^2) normal-basis multiplier, two-stage valid/ready pipeline
module gf24mul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] q
);
  function automatic logic [1:0] m4(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction
  logic [1:0] c, n;
  always_comb begin
    c = m4(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
    n = {c[0], c[1] ^ c[0]};
    q = {m4(a[3:2], b[3:2]) ^ n, m4(a[1:0], b[1:0]) ^ n};
  end
endmodule

module gf24mul_dom_pipe #(
  parameter int SHARES = 2,
  parameter bit ZERO_IDLE = 1'b1,
  localparam int NRND = SHARES * (SHARES - 1) / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*SHARES-1:0]   a_sh,
  input  logic [4*SHARES-1:0]   b_sh,
  input  logic [4*NRND-1:0]     rnd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*SHARES-1:0]   q_sh,
  output logic                  busy
);
  localparam int NC = SHARES * SHARES;
  logic [4*NC-1:0] p, c_d, c_q;
  logic [4*SHARES-1:0] q_d;
  logic s1_valid, s2_valid, s2_adv, acc, s2_free;
  assign s2_adv = s1_valid & (~s2_valid | out_ready);
  assign s2_free = ~s2_valid | out_ready;
  assign in_ready = ~s1_valid | s2_adv;
  assign acc = in_valid & in_ready;
  assign out_valid = s2_valid;
  assign busy = s1_valid | s2_valid;
  for (genvar i = 0; i < SHARES; i++) begin : g_i
    for (genvar j = 0; j < SHARES; j++) begin : g_j
      gf24mul u_mul (.a(a_sh[4*i+:4]), .b(b_sh[4*j+:4]), .q(p[4*(i*SHARES+j)+:4]));
      if (i == j) begin : g_d
        assign c_d[4*(i*SHARES+j)+:4] = p[4*(i*SHARES+j)+:4];
      end else begin : g_r
        // both c[i][j] and c[j][i] take the mask nibble of the unordered pair (min, max)
        localparam int lo = i < j ? i : j;
        localparam int hi = i < j ? j : i;
        localparam int k = lo * SHARES - lo * (lo + 1) / 2 + hi - lo - 1;
        assign c_d[4*(i*SHARES+j)+:4] = p[4*(i*SHARES+j)+:4] ^ rnd[4*k+:4];
      end
    end
  end
  always_comb begin
    q_d = '0;
    for (int i = 0; i < SHARES; i++)
      for (int j = 0; j < SHARES; j++)
        q_d[4*i+:4] = q_d[4*i+:4] ^ c_q[4*(i*SHARES+j)+:4];
  end
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      c_q <= '0;
      q_sh <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (acc) c_q <= c_d;
      else if (in_ready && ZERO_IDLE) c_q <= '0;
      if (s2_free) s2_valid <= s1_valid;
      if (s2_adv) q_sh <= q_d;
      else if (s2_free && ZERO_IDLE) q_sh <= '0;
    end
endmodule

// File: tb/tb_gf24mul_dom_pipe.sv
// tb_gf24mul_dom_pipe: randomized self-checking bench against an algebraic GF((2^2)^2) model
module tb_gf24mul_dom_pipe;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic iv2, ir2, ov2, or2, busy2;
  logic [7:0] a2, b2, q2;
  logic [3:0] r2;
  logic iv3, ir3, ov3, or3, busy3;
  logic [11:0] a3, b3, q3, r3;
  int tests = 0, fails = 0;
  logic [3:0] exp2[$], exp3[$];

  gf24mul_dom_pipe #(.SHARES(2), .ZERO_IDLE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a_sh(a2), .b_sh(b2), .rnd(r2),
    .out_valid(ov2), .out_ready(or2), .q_sh(q2), .busy(busy2));
  gf24mul_dom_pipe #(.SHARES(3), .ZERO_IDLE(1'b1)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a_sh(a3), .b_sh(b3), .rnd(r3),
    .out_valid(ov3), .out_ready(or3), .q_sh(q3), .busy(busy3));

  // GF(4): 2'b11 = 1, 2'b10 = W, 2'b01 = W^2, multiplied through discrete logs
  function automatic int lg(input logic [1:0] x);
    return x == 2'b11 ? 0 : x == 2'b10 ? 1 : 2;
  endfunction
  function automatic logic [1:0] g4(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] al [3];
    al = '{2'b11, 2'b10, 2'b01};
    if (x == 2'b00 || y == 2'b00) return 2'b00;
    return al[(lg(x) + lg(y)) % 3];
  endfunction
  // GF(16) = GF(4)[Z]/(Z^2+Z+N), N=W, basis {Z^4, Z}; bilinear expansion over basis products
  function automatic logic [3:0] fmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] bp [4];
    logic [3:0] r, e;
    logic [1:0] s, au, bv;
    bp = '{4'h6, 4'hA, 4'hA, 4'h9};
    r = 4'h0;
    for (int u = 0; u < 2; u++)
      for (int v = 0; v < 2; v++) begin
        au = u == 0 ? a[3:2] : a[1:0];
        bv = v == 0 ? b[3:2] : b[1:0];
        s = g4(au, bv);
        e = bp[u*2+v];
        r = r ^ {g4(s, e[3:2]), g4(s, e[1:0])};
      end
    return r;
  endfunction
  function automatic logic [7:0] sh2(input logic [3:0] x);
    logic [3:0] s;
    s = 4'($urandom);
    return {x ^ s, s};
  endfunction
  function automatic logic [11:0] sh3(input logic [3:0] x);
    logic [3:0] s, t;
    s = 4'($urandom);
    t = 4'($urandom);
    return {x ^ s ^ t, t, s};
  endfunction

  task automatic cyc2(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] r,
                      input logic ordy, output logic acc, output logic ov, output logic [7:0] q);
    @(negedge clk);
    iv2 = v; a2 = a; b2 = b; r2 = r; or2 = ordy;
    #1;
    acc = iv2 & ir2; ov = ov2; q = q2;
    if (acc) exp2.push_back(fmul(a[7:4] ^ a[3:0], b[7:4] ^ b[3:0]));
  endtask
  task automatic cyc3(input logic v, input logic [11:0] a, input logic [11:0] b, input logic [11:0] r,
                      input logic ordy, output logic acc, output logic ov, output logic [11:0] q);
    @(negedge clk);
    iv3 = v; a3 = a; b3 = b; r3 = r; or3 = ordy;
    #1;
    acc = iv3 & ir3; ov = ov3; q = q3;
    if (acc) exp3.push_back(fmul(a[11:8] ^ a[7:4] ^ a[3:0], b[11:8] ^ b[7:4] ^ b[3:0]));
  endtask

  task automatic test_reset();
    iv2 = 0; a2 = 0; b2 = 0; r2 = 0; or2 = 1;
    iv3 = 0; a3 = 0; b3 = 0; r3 = 0; or3 = 1;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    tests++; if (ov2 !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b want 0", ov2); end
    tests++; if (q2 !== 8'h00) begin fails++; $display("FAIL reset q_sh: got %h want 00", q2); end
    tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", busy2); end
    tests++; if (ir2 !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b want 1", ir2); end
    tests++; if (ov3 !== 1'b0 || q3 !== 12'h000) begin fails++; $display("FAIL reset3: got ov=%b q=%h want 0/000", ov3, q3); end
  endtask

  task automatic test_vector();
    logic acc, ov;
    logic [7:0] q;
    cyc2(1, 8'hC3, 8'hC5, 4'hA, 1, acc, ov, q);
    tests++; if (acc !== 1'b1) begin fails++; $display("FAIL vec accept: got %b want 1", acc); end
    cyc2(0, 0, 0, 0, 1, acc, ov, q);
    tests++; if (ov !== 1'b0) begin fails++; $display("FAIL vec early out_valid: got %b want 0", ov); end
    cyc2(0, 0, 0, 0, 1, acc, ov, q);
    tests++; if (ov !== 1'b1) begin fails++; $display("FAIL vec latency out_valid: got %b want 1", ov); end
    tests++; if ((q[7:4] ^ q[3:0]) !== 4'h9) begin fails++; $display("FAIL vec result: got %h want 9", q[7:4] ^ q[3:0]); end
    tests++; if (dut2.c_q !== 16'h0000) begin fails++; $display("FAIL zero_idle stage1: got %h want 0000", dut2.c_q); end
    cyc2(0, 0, 0, 0, 1, acc, ov, q);
    tests++; if (q !== 8'h00 || ov !== 1'b0 || busy2 !== 1'b0) begin
      fails++; $display("FAIL zero_idle q_sh: got q=%h ov=%b busy=%b want 00/0/0", q, ov, busy2); end
    exp2.delete();
  endtask

  task automatic test_exhaustive2();
    logic acc, ov, v;
    logic [7:0] q;
    logic [3:0] e;
    for (int i = 0; i < 260; i++) begin
      v = i < 256;
      cyc2(v, sh2(4'(i >> 4)), sh2(4'(i)), 4'($urandom), 1, acc, ov, q);
      tests++; if (acc !== v) begin fails++; $display("FAIL exh2 accept %0d: got %b want %b", i, acc, v); end
      tests++; if (ov !== (i >= 2 && i < 258)) begin fails++; $display("FAIL exh2 out_valid %0d: got %b", i, ov); end
      if (ov) begin
        e = exp2.size() > 0 ? exp2.pop_front() : 4'hx;
        tests++; if ((q[7:4] ^ q[3:0]) !== e) begin fails++; $display("FAIL exh2 product %0d: got %h want %h", i, q[7:4] ^ q[3:0], e); end
      end
    end
    exp2.delete();
  endtask

  task automatic test_exhaustive3();
    logic acc, ov, v;
    logic [11:0] q;
    logic [3:0] e;
    for (int i = 0; i < 260; i++) begin
      v = i < 256;
      cyc3(v, sh3(4'(i >> 4)), sh3(4'(i)), 12'($urandom), 1, acc, ov, q);
      tests++; if (acc !== v) begin fails++; $display("FAIL exh3 accept %0d: got %b want %b", i, acc, v); end
      tests++; if (ov !== (i >= 2 && i < 258)) begin fails++; $display("FAIL exh3 out_valid %0d: got %b", i, ov); end
      if (ov) begin
        e = exp3.size() > 0 ? exp3.pop_front() : 4'hx;
        tests++; if ((q[11:8] ^ q[7:4] ^ q[3:0]) !== e) begin
          fails++; $display("FAIL exh3 product %0d: got %h want %h", i, q[11:8] ^ q[7:4] ^ q[3:0], e); end
      end
    end
    exp3.delete();
  endtask

  task automatic test_zero_operand();
    logic acc, ov;
    logic [7:0] q, bs, qa, qb, qc;
    logic [3:0] s, b, r;
    s = 4'($urandom_range(1, 15));
    b = 4'($urandom_range(1, 15));
    r = 4'($urandom_range(1, 15));
    if (r == fmul(s, b)) r = r == 4'hF ? 4'h1 : r + 4'h1;
    bs = sh2(b);
    cyc2(1, {s, s}, bs, r, 1, acc, ov, q);
    cyc2(1, {s, s}, bs, 4'h0, 1, acc, ov, q);
    cyc2(1, {s, s}, bs, 4'h5, 1, acc, ov, qa);
    cyc2(0, 0, 0, 0, 1, acc, ov, qb);
    cyc2(0, 0, 0, 0, 1, acc, ov, qc);
    tests++; if ((qa[7:4] ^ qa[3:0]) !== 4'h0) begin fails++; $display("FAIL zero product: got %h want 0", qa[7:4] ^ qa[3:0]); end
    tests++; if (qa[3:0] === 4'h0 || qa[7:4] === 4'h0) begin fails++; $display("FAIL zero shares: got %h want both nibbles nonzero", qa); end
    tests++; if ((qb[3:0] ^ qc[3:0]) !== 4'h5) begin fails++; $display("FAIL rnd q0 delta: got %h want 5", qb[3:0] ^ qc[3:0]); end
    tests++; if ((qb[7:4] ^ qc[7:4]) !== 4'h5) begin fails++; $display("FAIL rnd q1 delta: got %h want 5", qb[7:4] ^ qc[7:4]); end
    exp2.delete();
  endtask

  task automatic test_backpressure();
    logic acc, ov, ordy, held, v;
    logic [7:0] q, hq;
    logic [3:0] e;
    int sent = 0, got = 0, occ = 0, cyc = 0, stalls = 0;
    held = 0; hq = 0;
    while (got < 8 && cyc < 100) begin
      ordy = !(cyc >= 3 && cyc < 8);
      v = sent < 8;
      cyc2(v, sh2(4'($urandom)), sh2(4'($urandom)), 4'($urandom), ordy, acc, ov, q);
      tests++; if (ir2 !== !(occ == 2 && !ordy)) begin
        fails++; $display("FAIL bp in_ready cyc %0d: got %b want %b", cyc, ir2, !(occ == 2 && !ordy)); end
      if (!ir2) stalls++;
      if (held) begin
        tests++; if (ov !== 1'b1 || q !== hq) begin fails++; $display("FAIL bp hold cyc %0d: got %b/%h want 1/%h", cyc, ov, q, hq); end
      end
      if (ov && ordy) begin
        e = exp2.size() > 0 ? exp2.pop_front() : 4'hx;
        tests++; if ((q[7:4] ^ q[3:0]) !== e) begin fails++; $display("FAIL bp order %0d: got %h want %h", got, q[7:4] ^ q[3:0], e); end
        got++;
      end
      held = ov && !ordy;
      hq = q;
      if (acc) sent++;
      occ = occ + int'(acc) - int'(ov && ordy);
      cyc++;
    end
    tests++; if (got != 8 || exp2.size() != 0) begin fails++; $display("FAIL bp count: got %0d left %0d want 8/0", got, exp2.size()); end
    tests++; if (stalls != 5) begin fails++; $display("FAIL bp stalls: got %0d want 5", stalls); end
    exp2.delete();
  endtask

  task automatic test_reset_mid();
    logic acc, ov;
    logic [7:0] q;
    logic [3:0] e;
    cyc2(1, sh2(4'h7), sh2(4'h3), 4'h1, 0, acc, ov, q);
    cyc2(1, sh2(4'h2), sh2(4'hE), 4'h2, 0, acc, ov, q);
    cyc2(1, sh2(4'h4), sh2(4'h6), 4'h3, 0, acc, ov, q);
    tests++; if (ov !== 1'b1 || ir2 !== 1'b0) begin fails++; $display("FAIL mid full: got ov=%b in_ready=%b want 1/0", ov, ir2); end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; iv2 = 0;
    #1;
    tests++; if (ov2 !== 1'b0 || busy2 !== 1'b0 || q2 !== 8'h00 || ir2 !== 1'b1) begin
      fails++; $display("FAIL mid reset: got ov=%b busy=%b q=%h rdy=%b want 0/0/00/1", ov2, busy2, q2, ir2); end
    exp2.delete();
    cyc2(1, sh2(4'hB), sh2(4'hD), 4'($urandom), 1, acc, ov, q);
    tests++; if (acc !== 1'b1 || ov !== 1'b0) begin fails++; $display("FAIL post accept: got acc=%b ov=%b want 1/0", acc, ov); end
    cyc2(0, 0, 0, 0, 1, acc, ov, q);
    tests++; if (ov !== 1'b0) begin fails++; $display("FAIL post early: got %b want 0", ov); end
    cyc2(0, 0, 0, 0, 1, acc, ov, q);
    e = fmul(4'hB, 4'hD);
    tests++; if (ov !== 1'b1 || (q[7:4] ^ q[3:0]) !== e) begin
      fails++; $display("FAIL post result: got ov=%b q=%h want 1/%h", ov, q[7:4] ^ q[3:0], e); end
    exp2.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vector();
    test_exhaustive2();
    test_exhaustive3();
    test_zero_operand();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
